// File: rtl/mips_ext_pkg.sv
// Shared immediate/shamt extension definitions for the MIPS datapath.
// ext_apply works on maximum-width vectors so any legal DATA_W/IMM_W/SA_W combination can use it.
package mips_ext_pkg;

    localparam int EXT_MAX_DATA_W = 64;
    localparam int EXT_MAX_IMM_W  = 32;
    localparam int EXT_MAX_SA_W   = 16;

    typedef enum logic [2:0] {
        EXT_ZERO    = 3'd0,
        EXT_SIGN    = 3'd1,
        EXT_LUI     = 3'd2,
        EXT_BRANCH  = 3'd3,
        EXT_SA_ZERO = 3'd4,
        EXT_SA_SIGN = 3'd5
    } ext_mode_t;

    function automatic logic ext_is_reserved(input ext_mode_t mode);
        return (mode > EXT_SA_SIGN);
    endfunction

    // Fields are masked to their real widths first, so stray upper input bits never leak into the result.
    function automatic logic [EXT_MAX_DATA_W-1:0] ext_apply(
        input ext_mode_t                 mode,
        input logic [EXT_MAX_IMM_W-1:0]  imm,
        input logic [EXT_MAX_SA_W-1:0]   sa,
        input int                        data_w,
        input int                        imm_w,
        input int                        sa_w
    );
        logic [EXT_MAX_DATA_W-1:0] imm_mask;
        logic [EXT_MAX_DATA_W-1:0] sa_mask;
        logic [EXT_MAX_DATA_W-1:0] data_mask;
        logic [EXT_MAX_DATA_W-1:0] imm_z;
        logic [EXT_MAX_DATA_W-1:0] imm_s;
        logic [EXT_MAX_DATA_W-1:0] sa_z;
        logic [EXT_MAX_DATA_W-1:0] sa_s;
        logic [EXT_MAX_DATA_W-1:0] res;

        imm_mask  = (64'd1 << imm_w) - 64'd1;
        sa_mask   = (64'd1 << sa_w) - 64'd1;
        data_mask = (64'd1 << data_w) - 64'd1;

        imm_z = EXT_MAX_DATA_W'(imm) & imm_mask;
        sa_z  = EXT_MAX_DATA_W'(sa) & sa_mask;
        imm_s = (((imm_z >> (imm_w - 1)) & 64'd1) != 64'd0) ? (imm_z | ~imm_mask) : imm_z;
        sa_s  = (((sa_z >> (sa_w - 1)) & 64'd1) != 64'd0) ? (sa_z | ~sa_mask) : sa_z;

        res = '0;
        case (mode)
            EXT_ZERO:    res = imm_z;
            EXT_SIGN:    res = imm_s;
            EXT_LUI:     res = imm_z << (data_w - imm_w);
            EXT_BRANCH:  res = imm_s << 2;
            EXT_SA_ZERO: res = sa_z;
            EXT_SA_SIGN: res = sa_s;
            default:     res = '0;
        endcase
        return res & data_mask;
    endfunction

endpackage

// File: rtl/skid_buf.sv
// Generic two-entry valid/ready register slice; in_ready depends only on registered state.
module skid_buf #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_valid, main_valid_nxt;
    logic [W-1:0] main_data, main_data_nxt;
    logic         skid_valid, skid_valid_nxt;
    logic [W-1:0] skid_data, skid_data_nxt;
    logic         accept;
    logic         xfer;

    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign accept    = in_valid && !skid_valid;
    assign xfer      = main_valid && out_ready;

    // Skid only fills while main is stalled, so a freed main always takes skid before any new input.
    always_comb begin
        main_valid_nxt = main_valid;
        main_data_nxt  = main_data;
        skid_valid_nxt = skid_valid;
        skid_data_nxt  = skid_data;
        if (xfer || !main_valid) begin
            if (skid_valid) begin
                main_valid_nxt = 1'b1;
                main_data_nxt  = skid_data;
                skid_valid_nxt = 1'b0;
            end else begin
                main_valid_nxt = accept;
                if (accept) begin
                    main_data_nxt = in_data;
                end
            end
        end else if (accept) begin
            skid_valid_nxt = 1'b1;
            skid_data_nxt  = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else begin
            main_valid <= main_valid_nxt;
            main_data  <= main_data_nxt;
            skid_valid <= skid_valid_nxt;
            skid_data  <= skid_data_nxt;
        end
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate/shift-amount extender: combinational ext_apply feeding a two-entry skid buffer.
module imm_ext_pipe
    import mips_ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int SA_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_mode,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [SA_W-1:0]   in_sa,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err
);

    generate
        if (DATA_W < IMM_W + 2 || DATA_W < SA_W || DATA_W > EXT_MAX_DATA_W ||
            IMM_W > EXT_MAX_IMM_W || SA_W > EXT_MAX_SA_W) begin : g_bad_params
            $error("imm_ext_pipe: illegal DATA_W/IMM_W/SA_W combination");
        end
    endgenerate

    ext_mode_t         mode;
    logic [DATA_W-1:0] ext_data;
    logic              ext_err;
    logic [DATA_W:0]   buf_out;

    assign mode     = ext_mode_t'(in_mode);
    assign ext_data = DATA_W'(ext_apply(mode, EXT_MAX_IMM_W'(in_imm), EXT_MAX_SA_W'(in_sa),
                                        DATA_W, IMM_W, SA_W));
    assign ext_err  = ext_is_reserved(mode);

    skid_buf #(
        .W(DATA_W + 1)
    ) u_skid_buf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({ext_err, ext_data}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (buf_out)
    );

    assign out_err  = buf_out[DATA_W];
    assign out_data = buf_out[DATA_W-1:0];

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe: directed scenarios plus a randomized scoreboard run.
module tb_imm_ext_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_mode = 3'd0;
    logic [15:0] in_imm = 16'd0;
    logic [4:0]  in_sa = 5'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_err;

    logic        w_in_valid = 1'b0;
    logic        w_in_ready;
    logic [2:0]  w_in_mode = 3'd0;
    logic [15:0] w_in_imm = 16'd0;
    logic [5:0]  w_in_sa = 6'd0;
    logic        w_out_valid;
    logic        w_out_ready = 1'b1;
    logic [63:0] w_out_data;
    logic        w_out_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    imm_ext_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_imm(in_imm), .in_sa(in_sa),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
    );

    imm_ext_pipe #(.DATA_W(64), .IMM_W(16), .SA_W(6)) dut_wide (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_mode(w_in_mode), .in_imm(w_in_imm), .in_sa(w_in_sa),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data), .out_err(w_out_err)
    );

    // Reference: treat fields as integers, sign-extend by subtracting 2^width, wrap modulo 2^dw.
    function automatic logic [63:0] ref_ext(input int mode, input longint imm, input longint sa,
                                            input int dw, input int iw, input int sw);
        longint s_imm;
        longint s_sa;
        logic [63:0] r;
        s_imm = (imm >= (longint'(1) << (iw - 1))) ? imm - (longint'(1) << iw) : imm;
        s_sa  = (sa >= (longint'(1) << (sw - 1))) ? sa - (longint'(1) << sw) : sa;
        case (mode)
            0: r = 64'(imm);
            1: r = 64'(s_imm);
            2: r = 64'(imm) << (dw - iw);
            3: r = 64'(s_imm * 4);
            4: r = 64'(sa);
            5: r = 64'(s_sa);
            default: r = 64'd0;
        endcase
        if (dw < 64) r = r & ((64'd1 << dw) - 64'd1);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_out_data got %h want 0", out_data); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_err got %b want 0", out_err); end
        rst = 1'b0;
    endtask

    task automatic test_mode_sweep();
        logic [31:0] exp_tab [6] = '{32'h00008001, 32'hFFFF8001, 32'h80010000,
                                     32'hFFFE0004, 32'h00000013, 32'hFFFFFFF3};
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1; in_mode = 3'(k); in_imm = 16'h8001; in_sa = 5'h13;
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_tab[k] || out_err !== 1'b0) begin
                errors++;
                $display("[TB] FAIL sweep_mode%0d got v=%b d=%h e=%b want v=1 d=%h e=0",
                         k, out_valid, out_data, out_err, exp_tab[k]);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reserved_and_boundary();
        logic [2:0]  m_tab [5] = '{3'd6, 3'd0, 3'd1, 3'd3, 3'd5};
        logic [15:0] i_tab [5] = '{16'h1234, 16'h0001, 16'h8000, 16'hFFFF, 16'h0000};
        logic [4:0]  s_tab [5] = '{5'h00, 5'h00, 5'h00, 5'h00, 5'h10};
        logic [31:0] d_tab [5] = '{32'h0, 32'h1, 32'hFFFF8000, 32'hFFFFFFFC, 32'hFFFFFFF0};
        logic        e_tab [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_mode = m_tab[k]; in_imm = i_tab[k]; in_sa = s_tab[k];
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== d_tab[k] || out_err !== e_tab[k]) begin
                errors++;
                $display("[TB] FAIL directed_%0d got v=%b d=%h e=%b want v=1 d=%h e=%b",
                         k, out_valid, out_data, out_err, d_tab[k], e_tab[k]);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_mode = 3'd0; in_imm = 16'h0011; in_sa = 5'd0;
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h00000011 || in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL bp_first got v=%b d=%h rdy=%b want v=1 d=00000011 rdy=1", out_valid, out_data, in_ready); end
        in_mode = 3'd1; in_imm = 16'hF000;
        tick();
        checks++; if (in_ready !== 1'b0 || out_data !== 32'h00000011) begin
            errors++; $display("[TB] FAIL bp_full got rdy=%b d=%h want rdy=0 d=00000011", in_ready, out_data); end
        in_mode = 3'd2; in_imm = 16'h00AB;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h00000011) begin
                errors++; $display("[TB] FAIL bp_hold%0d got rdy=%b v=%b d=%h want rdy=0 v=1 d=00000011", k, in_ready, out_valid, out_data); end
        end
        out_ready = 1'b1;
        tick();
        checks++; if (out_data !== 32'hFFFFF000 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL bp_drain1 got v=%b d=%h rdy=%b want v=1 d=fffff000 rdy=1", out_valid, out_data, in_ready); end
        tick();
        checks++; if (out_data !== 32'h00AB0000 || out_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL bp_drain2 got v=%b d=%h want v=1 d=00ab0000", out_valid, out_data); end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL bp_empty got v=%b want 0", out_valid); end
    endtask

    task automatic test_random();
        logic [32:0] q [$];
        logic [32:0] exp_v;
        logic [32:0] stall_v;
        logic        stall_pending;
        stall_pending = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (stall_pending) begin
                checks++;
                if (out_valid !== 1'b1 || {out_err, out_data} !== stall_v) begin
                    errors++; $display("[TB] FAIL rand_stall cyc=%0d got v=%b d=%h want v=1 d=%h", cyc, out_valid, {out_err, out_data}, stall_v);
                end
            end
            checks++;
            if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
                errors++; $display("[TB] FAIL rand_flags cyc=%0d got v=%b rdy=%b want occupancy %0d", cyc, out_valid, in_ready, q.size());
            end
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_mode   = 3'($urandom_range(0, 7));
            in_imm    = 16'($urandom);
            in_sa     = 5'($urandom);
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("[TB] FAIL rand_spurious cyc=%0d got d=%h want none", cyc, out_data);
                end else begin
                    exp_v = q.pop_front();
                    if ({out_err, out_data} !== exp_v) begin
                        errors++; $display("[TB] FAIL rand_data cyc=%0d got %h want %h", cyc, {out_err, out_data}, exp_v);
                    end
                end
            end
            stall_pending = out_valid && !out_ready;
            stall_v = {out_err, out_data};
            if (in_valid && in_ready)
                q.push_back({(in_mode > 3'd5), 32'(ref_ext(int'(in_mode), longint'(in_imm), longint'(in_sa), 32, 16, 5))});
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 10 && (out_valid || q.size() > 0); k++) begin
            if (out_valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("[TB] FAIL rand_drain_spurious got d=%h want none", out_data);
                end else begin
                    exp_v = q.pop_front();
                    if ({out_err, out_data} !== exp_v) begin
                        errors++; $display("[TB] FAIL rand_drain got %h want %h", {out_err, out_data}, exp_v);
                    end
                end
            end
            tick();
        end
        checks++;
        if (q.size() != 0 || out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL rand_leftover got %0d pending v=%b want 0 pending v=0", q.size(), out_valid);
        end
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0;
        in_valid = 1'b1; in_mode = 3'd0; in_imm = 16'h5555; in_sa = 5'd0;
        tick();
        in_imm = 16'h6666;
        tick();
        checks++; if (in_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL rstfull_prefill got rdy=%b want 0", in_ready); end
        rst = 1'b1; out_ready = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'd0) begin
            errors++; $display("[TB] FAIL rstfull_state got v=%b rdy=%b d=%h want v=0 rdy=1 d=0", out_valid, in_ready, out_data); end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin
                errors++; $display("[TB] FAIL rstfull_stale%0d got v=%b d=%h want v=0", k, out_valid, out_data); end
        end
    endtask

    task automatic test_wide();
        logic [2:0]  m_tab [2] = '{3'd2, 3'd5};
        logic [15:0] i_tab [2] = '{16'hABCD, 16'h0000};
        logic [5:0]  s_tab [2] = '{6'h00, 6'h20};
        logic [63:0] d_tab [2] = '{64'hABCD000000000000, 64'hFFFFFFFFFFFFFFE0};
        w_out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            w_in_valid = 1'b1; w_in_mode = m_tab[k]; w_in_imm = i_tab[k]; w_in_sa = s_tab[k];
            tick();
            checks++;
            if (w_out_valid !== 1'b1 || w_out_data !== d_tab[k] ||
                w_out_data !== ref_ext(int'(m_tab[k]), longint'(i_tab[k]), longint'(s_tab[k]), 64, 16, 6)) begin
                errors++; $display("[TB] FAIL wide_%0d got v=%b d=%h want v=1 d=%h", k, w_out_valid, w_out_data, d_tab[k]);
            end
        end
        w_in_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_mode_sweep();
        test_reserved_and_boundary();
        test_backpressure();
        test_random();
        test_reset_full();
        test_wide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
